ffa_access_arbiter: RTL and testbench
=====================================

Name: ffa_access_arbiter

Overview:
- Shares one Flip_Flop_Array register file between REQ_N independent requesters.
- Arbitrates round-robin, latches the winning request, and drives exactly one array read or write.
- Captures the array's combinational dout/error and returns a one-cycle response to the owning requester.
- Sits between client logic and the array. It is the only agent driving the array's din/addr/wr/rd.

Parameters:
- DATA_W, 8, data width; must match the array.
- ADDR_W, 3, address width; must match the array.
- REQ_N, 4, number of requesters, 2..8.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  REQ_N  per-requester request valid.
- req_wr  in  REQ_N  1 = write, 0 = read.
- req_addr  in  REQ_N*ADDR_W  packed addresses; requester i at slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  REQ_N*DATA_W  packed write data; same slicing.
- req_ready  out  REQ_N  one-hot grant/accept pulse.
- rsp_valid  out  REQ_N  one-hot response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_error  out  1  array error for this access.
- arr_din  out  DATA_W  to array din.
- arr_addr  out  ADDR_W  to array addr.
- arr_wr  out  1  to array wr.
- arr_rd  out  1  to array rd.
- arr_dout  in  DATA_W  from array dout.
- arr_error  in  1  from array error.

Behaviour:
- Reset (async, resetn=0):
  - State=IDLE; rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
  - arr_wr=0, arr_rd=0, arr_din=0, arr_addr=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Sample req_valid each cycle. If nonzero, pick winner = first set bit at or after rr_ptr, wrapping modulo REQ_N.
  - Pulse req_ready[winner] combinationally in that cycle. The handshake completes on req_valid & req_ready at that edge.
  - Latch winner index, wr, addr, wdata → ISSUE.
  - If req_valid is zero, stay in IDLE.
- ISSUE (exactly one cycle):
  - Drive arr_addr and arr_din from the latch.
  - Drive arr_wr=latched wr and arr_rd=~latched wr. Never assert both.
  - At the clock edge, register rsp_rdata = wr ? 0 : arr_dout and rsp_error = arr_error → RESP.
- RESP (exactly one cycle):
  - rsp_valid[owner]=1.
  - rr_ptr <= (owner+1) mod REQ_N → IDLE.
- Timing:
  - Latency from grant to rsp_valid is 2 cycles.
  - Peak throughput is 1 access per 3 cycles.
  - arr_wr/arr_rd are 0 outside ISSUE. arr_addr/arr_din hold their last value.
- Requester rules:
  - A requester may deassert valid before it is granted; no effect.
  - After grant, its payload is ignored; the latched copy is used.
  - A requester may re-request in the IDLE cycle after its RESP. It then has lowest priority if others are valid.
- Fairness: any continuously valid requester is granted within REQ_N grants.
- Wrap: rr_ptr = REQ_N-1 with owner REQ_N-1 → rr_ptr = 0.
- Read of an unwritten/invalid entry: pass through arr_error=1 and arr_dout=0 unmodified. No retry.
- Reset mid-operation: the in-flight access is dropped, with no rsp_valid. An array write in ISSUE may already have landed; this is acceptable.
- Pulses: req_ready and rsp_valid are each at most one-hot.

Optional Feature:
- Macro: FFA_ARB_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], a saturating count of RESP cycles with rsp_error=1.
  - Saturates at 255.
  - Reset to 0 asynchronously.
  - Adds input err_clr; err_clr=1 clears it synchronously. If a clear and an error coincide, the clear wins.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package ffa_pkg:
  - State enum typedef (IDLE/ISSUE/RESP).
  - Latched request struct typedef {wr, addr, wdata, owner}.
  - Default width localparams.
- Sub-module ffa_rr_pick: combinational round-robin picker (req vector, rr_ptr → one-hot grant + index). Reusable by other arbiters.

Test Plan:
- Write then read, single requester: req0 writes addr 3 = 0xA5, then reads addr 3 → two accesses. Read response: rsp_valid[0] 2 cycles after grant, rsp_rdata=0xA5, rsp_error=0.
- Read with no prior valid write: req1 reads addr 5 → rsp_error=1, rsp_rdata=0x00. arr_rd pulses once and arr_wr stays 0.
- Round-robin: all 4 requesters valid continuously from reset → grant order 0,1,2,3,0. Each req_ready is spaced 3 cycles apart.
- Wrap and skip: rr_ptr=3, only req3 and req1 valid → req3 granted, then req1. rr_ptr ends at 2.
- Reset in ISSUE: assert resetn=0 during ISSUE → all outputs 0 immediately, no rsp_valid. The first post-reset grant goes to the lowest valid index.
- With FFA_ARB_ERR_CNT_EN: 300 invalid reads → err_cnt=255. Pulse err_clr → err_cnt=0 next cycle.

Source files
------------

// File: rtl/ffa_pkg.sv
// Shared types and defaults for the Flip_Flop_Array access arbiter.
package ffa_pkg;

    localparam int FFA_DATA_W     = 8;
    localparam int FFA_ADDR_W     = 3;
    localparam int FFA_REQ_N      = 4;
    // Widest data/address the latched request struct can carry.
    localparam int FFA_DATA_W_MAX = 64;
    localparam int FFA_ADDR_W_MAX = 16;
    // Requester index width; REQ_N is limited to 8.
    localparam int FFA_IDX_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } ffa_state_e;

    typedef struct packed {
        logic                      wr;
        logic [FFA_ADDR_W_MAX-1:0] addr;
        logic [FFA_DATA_W_MAX-1:0] wdata;
        logic [FFA_IDX_W-1:0]      owner;
    } ffa_req_t;

    // Pointer just past the owner, wrapping modulo req_n.
    function automatic logic [FFA_IDX_W-1:0] ffa_next_ptr(input logic [FFA_IDX_W-1:0] owner,
                                                          input int req_n);
        if (int'(owner) == req_n - 1)
            ffa_next_ptr = '0;
        else
            ffa_next_ptr = owner + FFA_IDX_W'(1);
    endfunction

endpackage

// File: rtl/ffa_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo REQ_N, returned both one-hot and as an index.
module ffa_rr_pick
    import ffa_pkg::*;
#(
    parameter int REQ_N = 4
)(
    input  logic [REQ_N-1:0]     i_req,
    input  logic [FFA_IDX_W-1:0] i_ptr,
    output logic [REQ_N-1:0]     o_grant,
    output logic [FFA_IDX_W-1:0] o_idx,
    output logic                 o_any
);

    // Scan from the farthest offset back toward the pointer so the nearest request wins.
    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = REQ_N - 1; k >= 0; k--) begin
            j = (int'(i_ptr) + k) % REQ_N;
            if (i_req[j]) begin
                o_grant    = '0;
                o_grant[j] = 1'b1;
                o_idx      = FFA_IDX_W'(j);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ffa_access_arbiter.sv
// Round-robin arbiter sharing one Flip_Flop_Array between REQ_N requesters.
// Each access takes IDLE (grant) -> ISSUE (array strobe) -> RESP (response pulse).
// Optional build macro FFA_ARB_ERR_CNT_EN adds err_clr / err_cnt (saturating
// count of erroring responses).
module ffa_access_arbiter
    import ffa_pkg::*;
#(
    parameter int DATA_W = FFA_DATA_W,
    parameter int ADDR_W = FFA_ADDR_W,
    parameter int REQ_N  = FFA_REQ_N
)(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [REQ_N-1:0]         req_valid,
    input  logic [REQ_N-1:0]         req_wr,
    input  logic [REQ_N*ADDR_W-1:0]  req_addr,
    input  logic [REQ_N*DATA_W-1:0]  req_wdata,
    output logic [REQ_N-1:0]         req_ready,
    output logic [REQ_N-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_error,
    output logic [DATA_W-1:0]        arr_din,
    output logic [ADDR_W-1:0]        arr_addr,
    output logic                     arr_wr,
    output logic                     arr_rd,
    input  logic [DATA_W-1:0]        arr_dout,
    input  logic                     arr_error
`ifdef FFA_ARB_ERR_CNT_EN
    ,
    input  logic                     err_clr,
    output logic [7:0]               err_cnt
`endif
);

    ffa_state_e           r_state;
    ffa_state_e           w_next_state;
    logic [FFA_IDX_W-1:0] r_rr_ptr;
    ffa_req_t             r_lat;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_rsp_error;

    logic [REQ_N-1:0]     w_grant;
    logic [FFA_IDX_W-1:0] w_idx;
    logic                 w_any;
    logic                 w_sel_wr;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_unused_lat;

    ffa_rr_pick #(.REQ_N(REQ_N)) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Mux the winner's payload out of the packed request buses using the one-hot grant.
    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (w_grant[i]) begin
                w_sel_wr    = req_wr[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // State register; the pointer moves past the owner as its response goes out.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == RESP)
                r_rr_ptr <= ffa_next_ptr(r_lat.owner, REQ_N);
        end
    end

    // Next state: leave IDLE only on a grant; ISSUE and RESP last one cycle each.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = ISSUE;
            ISSUE:   w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch the winning request at the grant edge; the requester's live payload is ignored afterwards.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lat <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_lat.wr    <= w_sel_wr;
            r_lat.addr  <= FFA_ADDR_W_MAX'(w_sel_addr);
            r_lat.wdata <= FFA_DATA_W_MAX'(w_sel_wdata);
            r_lat.owner <= w_idx;
        end
    end

    // Capture the array's combinational read result at the end of ISSUE; writes return zero data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_rsp_rdata <= r_lat.wr ? '0 : arr_dout;
            r_rsp_error <= arr_error;
        end
    end

    // One-hot response pulse to the owner during RESP.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < REQ_N; i++)
            rsp_valid[i] = (r_state == RESP) && (r_lat.owner == FFA_IDX_W'(i));
    end

    // Grant is gated by resetn so no handshake can complete while reset is held.
    assign req_ready = (r_state == IDLE && resetn) ? w_grant : '0;
    assign arr_wr    = (r_state == ISSUE) &  r_lat.wr;
    assign arr_rd    = (r_state == ISSUE) & ~r_lat.wr;
    assign arr_addr  = r_lat.addr[ADDR_W-1:0];
    assign arr_din   = r_lat.wdata[DATA_W-1:0];
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;

    // Upper struct bits beyond the configured widths are always zero.
    assign w_unused_lat = ^{r_lat.addr, r_lat.wdata};

`ifdef FFA_ARB_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating error-response counter; a clear beats a coincident error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_err_cnt <= '0;
        else if (err_clr)
            r_err_cnt <= '0;
        else if (r_state == RESP && r_rsp_error && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_ffa_access_arbiter.sv
// Self-checking bench for ffa_access_arbiter: a transaction-level model
// checked every cycle plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_ffa_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, arr_din, arr_dout;
    logic            rsp_error, arr_wr, arr_rd, arr_error;
    logic [AW-1:0]   arr_addr;
`ifdef FFA_ARB_ERR_CNT_EN
    logic            err_clr = 1'b0;
    logic [7:0]      err_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ffa_access_arbiter #(.DATA_W(DW), .ADDR_W(AW), .REQ_N(N)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .arr_din(arr_din), .arr_addr(arr_addr), .arr_wr(arr_wr), .arr_rd(arr_rd),
        .arr_dout(arr_dout), .arr_error(arr_error)
`ifdef FFA_ARB_ERR_CNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        oh2i = -1;
        for (int i = 0; i < N; i++)
            if (v[i]) oh2i = i;
    endfunction

    // Array stand-in: unwritten entries read as 0 with error.
    logic [DW-1:0] amem [8] = '{default: '0};
    logic          aval [8] = '{default: 1'b0};
    always @(posedge clk)
        if (arr_wr) begin
            amem[arr_addr] <= arr_din;
            aval[arr_addr] <= 1'b1;
        end
    assign arr_dout  = aval[arr_addr] ? amem[arr_addr] : '0;
    assign arr_error = arr_rd & ~aval[arr_addr];

    // Transaction-level model: phase 0 = waiting for a grant, 1 = access, 2 = response.
    int            m_phase = 0, m_ptr = 0, m_owner = 0, m_cnt = 0;
    logic          m_wr = 1'b0, m_err = 1'b0;
    logic [AW-1:0] m_a = '0, m_addr_o = '0;
    logic [DW-1:0] m_d = '0, m_din_o = '0, m_rdata = '0;
    logic [DW-1:0] rmem [8] = '{default: '0};
    logic          rval [8] = '{default: 1'b0};

    always @(negedge clk) begin : model
        int j;
        logic [N-1:0] e_ready, e_rv;
        logic e_wr, e_rd;
        e_ready = '0; e_rv = '0; e_wr = 1'b0; e_rd = 1'b0;
        if (!resetn) begin
            m_phase = 0; m_ptr = 0; m_addr_o = '0; m_din_o = '0;
            m_rdata = '0; m_err = 1'b0; m_cnt = 0;
        end
        chk("arr_addr", 32'(arr_addr), 32'(m_addr_o));
        chk("arr_din", 32'(arr_din), 32'(m_din_o));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("rsp_error", 32'(rsp_error), 32'(m_err));
`ifdef FFA_ARB_ERR_CNT_EN
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        if (resetn && err_clr) m_cnt = 0;
        else if (resetn && m_phase == 2 && m_err && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
        if (resetn) begin
            case (m_phase)
                0: begin
                    for (int k = N - 1; k >= 0; k--) begin
                        j = (m_ptr + k) % N;
                        if (req_valid[j]) m_owner = j;
                    end
                    if (req_valid != '0) begin
                        e_ready[m_owner] = 1'b1;
                        m_wr = req_wr[m_owner];
                        m_a  = req_addr[m_owner*AW +: AW];
                        m_d  = req_wdata[m_owner*DW +: DW];
                        m_addr_o = m_a;
                        m_din_o  = m_d;
                        m_phase  = 1;
                    end
                end
                1: begin
                    e_wr = m_wr;
                    e_rd = !m_wr;
                    if (m_wr) begin
                        rmem[m_a] = m_d; rval[m_a] = 1'b1;
                        m_rdata = '0; m_err = 1'b0;
                    end else begin
                        m_rdata = rval[m_a] ? rmem[m_a] : '0;
                        m_err   = !rval[m_a];
                    end
                    m_phase = 2;
                end
                default: begin
                    e_rv[m_owner] = 1'b1;
                    m_ptr   = (m_owner + 1) % N;
                    m_phase = 0;
                end
            endcase
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("arr_wr", 32'(arr_wr), 32'(e_wr));
        chk("arr_rd", 32'(arr_rd), 32'(e_rd));
    end

    // Observation log for the literal scenario checks.
    int            g_idx[$];
    int            g_cyc[$];
    int            r_owner = -1, r_cyc = 0, n_rd = 0, n_wr = 0;
    logic [DW-1:0] r_data = '0;
    logic          r_err = 1'b0;
    int            rsp_cnt [N] = '{default: 0};

    always @(negedge clk) begin
        if (req_ready != '0) begin
            g_idx.push_back(oh2i(req_ready));
            g_cyc.push_back(cyc);
        end
        if (rsp_valid != '0) begin
            r_owner = oh2i(rsp_valid);
            r_cyc   = cyc;
            r_data  = rsp_rdata;
            r_err   = rsp_error;
            rsp_cnt[r_owner] = rsp_cnt[r_owner] + 1;
        end
        n_rd = n_rd + int'(arr_rd);
        n_wr = n_wr + int'(arr_wr);
    end

    task automatic set_pl(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Raise the masked requests and wait for ngr grants; without keep each winner drops its request.
    task automatic run_mask(input logic [N-1:0] mask, input logic [N-1:0] wrm,
                            input int ngr, input bit keep);
        int got, guard;
        logic [N-1:0] g;
        got = 0; guard = 0;
        req_valid = mask;
        req_wr    = wrm;
        while (got < ngr && guard < 60) begin
            @(negedge clk);
            guard++;
            g = req_ready;
            if (g != '0) begin
                got++;
                @(posedge clk); #1;
                if (got == ngr) req_valid = '0;
                else if (!keep) req_valid = req_valid & ~g;
            end
        end
        if (got < ngr) chk("grant_timeout", 32'(got), 32'(ngr));
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int b, rd0, wr0, cnt3, got, guard;
        int exp_rr [5] = '{0, 1, 2, 3, 0};
        int exp_wr [4] = '{2, 3, 1, 2};

        // Reset: grants must stay off even with requests pending.
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_arr_rd", 32'(arr_rd), 32'h0);
        chk("rst_arr_wr", 32'(arr_wr), 32'h0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        req_valid = '0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Write then read addr 3 from requester 0.
        set_pl(0, 3'd3, 8'hA5);
        run_mask(4'b0001, 4'b0001, 1, 1'b0);
        chk("wr_rsp_owner", 32'(r_owner), 32'd0);
        chk("wr_rsp_rdata", 32'(r_data), 32'h0);
        set_pl(0, 3'd3, 8'h00);
        b = g_idx.size();
        run_mask(4'b0001, 4'b0000, 1, 1'b0);
        chk("rd_rsp_owner", 32'(r_owner), 32'd0);
        chk("rd_rsp_rdata", 32'(r_data), 32'hA5);
        chk("rd_rsp_error", 32'(r_err), 32'h0);
        if (g_idx.size() > b) chk("rd_latency", 32'(r_cyc - g_cyc[b]), 32'd2);
        else chk("rd_grant_seen", 32'(g_idx.size() - b), 32'd1);

        // Read of an unwritten entry from requester 1.
        rd0 = n_rd; wr0 = n_wr;
        set_pl(1, 3'd5, 8'h00);
        run_mask(4'b0010, 4'b0000, 1, 1'b0);
        chk("unwr_owner", 32'(r_owner), 32'd1);
        chk("unwr_rdata", 32'(r_data), 32'h00);
        chk("unwr_error", 32'(r_err), 32'h1);
        chk("unwr_rd_pulses", 32'(n_rd - rd0), 32'd1);
        chk("unwr_wr_pulses", 32'(n_wr - wr0), 32'd0);

        // Round-robin from reset with all four requesters continuously valid.
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < N; i++) set_pl(i, AW'(i), 8'h00);
        b = g_idx.size();
        run_mask(4'hF, 4'h0, 5, 1'b1);
        chk("rr_count", 32'(g_idx.size() - b), 32'd5);
        if (g_idx.size() >= b + 5) begin
            for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), 32'(g_idx[b+k]), 32'(exp_rr[k]));
            for (int k = 0; k < 4; k++) chk($sformatf("rr_space%0d", k), 32'(g_cyc[b+k+1] - g_cyc[b+k]), 32'd3);
        end

        // Wrap and skip: move the pointer to 3, then req3+req1, then probe pointer with req0+req2.
        b = g_idx.size();
        run_mask(4'b0100, 4'b0000, 1, 1'b0);
        run_mask(4'b1010, 4'b0000, 2, 1'b0);
        run_mask(4'b0101, 4'b0000, 1, 1'b0);
        chk("wrap_count", 32'(g_idx.size() - b), 32'd4);
        if (g_idx.size() >= b + 4)
            for (int k = 0; k < 4; k++) chk($sformatf("wrap_order%0d", k), 32'(g_idx[b+k]), 32'(exp_wr[k]));

        // Reset while req3's access is in ISSUE.
        cnt3 = rsp_cnt[3];
        req_valid = 4'b1000;
        got = 0; guard = 0;
        while (!got && guard < 10) begin
            @(negedge clk);
            guard++;
            if (req_ready[3]) got = 1;
        end
        chk("mid_grant3", 32'(got), 32'd1);
        @(posedge clk); #1;
        resetn = 1'b0;
        req_valid = 4'b0110;
        @(negedge clk);
        chk("mid_arr_rd", 32'(arr_rd), 32'h0);
        chk("mid_arr_wr", 32'(arr_wr), 32'h0);
        chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_arr_addr", 32'(arr_addr), 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        b = g_idx.size();
        run_mask(4'b0110, 4'b0000, 1, 1'b0);
        if (g_idx.size() > b) chk("post_rst_grant", 32'(g_idx[b]), 32'd1);
        else chk("post_rst_grant_seen", 32'(g_idx.size() - b), 32'd1);
        chk("dropped_rsp3", 32'(rsp_cnt[3] - cnt3), 32'd0);

`ifdef FFA_ARB_ERR_CNT_EN
        // 300 erroring reads saturate the counter; a clear pulse zeroes it.
        set_pl(0, 3'd7, 8'h00);
        repeat (300) run_mask(4'b0001, 4'b0000, 1, 1'b0);
        chk("errcnt_sat", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("errcnt_clr", 32'(err_cnt), 32'd0);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
